pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and stage sequencer for the picoMips core, directly upstream of the instruction decoder. It drives the program-ROM address (PC) and the 2-bit execution `Stage` consumed by the decoder. It also synchronises the asynchronous handshake switch into `Handshake`. It consumes the decoder's `PCHold` to stall on the handshake-wait instruction.

## Interface
Parameters:
- `PC_WIDTH`, default 5: width of the program counter and ROM address.
- `LAST_ADDR`, default 31: highest program address; the PC wraps to 0 after it. Must be < 2^PC_WIDTH.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Run`  in  1  synchronous enable; 0 freezes `Stage` and `PC`.
- `HandshakeIn`  in  1  raw, asynchronous handshake switch.
- `PCHold`  in  1  decoder stall request; sampled only when `Stage`==2'b10.
- `PC`  out  PC_WIDTH  registered program-ROM address.
- `Stage`  out  2  registered execution stage: 00, 01, 10.
- `Handshake`  out  1  `HandshakeIn` after a 2-flop synchroniser.
- `InstrDone`  out  1  registered one-cycle pulse; a non-held instruction has retired.

## Operation
- Reset (async assert, sync-safe deassert by the system):
  - `PC`=0, `Stage`=2'b00.
  - Both synchroniser flops = 0, so `Handshake`=0.
  - `InstrDone`=0.
- Stage FSM, advancing only when `Run`=1:
  - S0 (00) → S1 (01) → S2 (10) → S0.
  - Code 11 is illegal. If ever held, the next edge forces 00, regardless of `Run`, and `PC` is unchanged.
- PC update, only on the S2→S0 edge:
  - `PCHold`=0: `PC` <= (`PC`==LAST_ADDR) ? 0 : `PC`+1. Arithmetic is unsigned, PC_WIDTH bits, with no carry out.
  - `PCHold`=1: `PC` unchanged. The held instruction re-executes S0..S2 until `PCHold` is low in S2.
  - `PCHold` in S0/S1 is ignored.
- `InstrDone`: set to 1 on the S2→S0 edge when `PCHold`=0 and `Run`=1; 0 on every other edge.
- `Run`=0: `Stage`, `PC` hold and `InstrDone`=0. The synchroniser keeps running.
- Synchroniser: `sync1` <= `HandshakeIn`; `Handshake` <= `sync1`. There is no other logic on this path.

## Timing
- Each instruction takes 3 cycles with `Run`=1 and no hold. The PC changes exactly once per 3 cycles, coincident with `Stage` returning to 00.
- `Handshake` latency: a `HandshakeIn` change is visible on `Handshake` after 2 rising edges. It has 1.x cycles of uncertainty relative to the asynchronous input.
- Stall loop:
  - The decoder's `PCHold` depends combinationally on `Stage` and `Handshake`. This block registers only; there is no combinational path from `PCHold` or `HandshakeIn` to any output.
  - Release latency is at most 2 sync edges + 3 stage cycles.
- Simultaneous events:
  - `Run` falling on the same edge as S2: `Run` wins; no PC update.
  - `PCHold`=1 while `PC`==LAST_ADDR: `PC` stays at LAST_ADDR; no wrap.
- Reset mid-instruction: immediate return to `PC`=0, `Stage`=00, `InstrDone`=0. No partial PC update survives.
- Outputs are glitch-free registers, except `Handshake`, which is also a register.

## Test plan
- Reset then `Run`=1 for 9 cycles:
  - `Stage` = 00,01,10,00,01,10,00,01,10.
  - `PC` = 0,0,0,1,1,1,2,2,2.
  - `InstrDone` high in the cycles where `PC` first shows 1 and 2.
- Wrap, LAST_ADDR=31: run until `PC`=31. The next S2→S0 edge gives `PC`=0 and `InstrDone`=1. Repeat with LAST_ADDR=5 to check 5→0.
- Hold:
  - At `PC`=3, drive `PCHold`=1 in S2 for 2 instruction loops. `PC` stays 3 for 6 extra cycles with no `InstrDone`.
  - Drop `PCHold` in the third S2. `PC`=4 next cycle.
  - Also verify that `PCHold`=1 only in S0/S1 has no effect.
- Handshake sync: toggle `HandshakeIn` 0→1 mid-cycle. `Handshake` rises after exactly 2 rising edges. A 1-cycle-wide pulse is passed through delayed by 2.
- `Run` gating: deassert `Run` in S1 at `PC`=2 for 4 cycles. `Stage`=01 and `PC`=2 hold, with no `InstrDone`. Resume gives 10, then 00 with `PC`=3.
- Reset mid-operation and illegal state:
  - Assert `reset` asynchronously in S2 with `PCHold`=0 at `PC`=7. `PC`=0 and `Stage`=00 immediately, with no increment after release.
  - Force `Stage`=11. The next edge gives 00 with `PC` unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and three-stage execution sequencer for the picoMips core.
// Also brings the asynchronous handshake switch into the clock domain.
module pc_sequencer #(
    parameter int PC_WIDTH  = 5,
    parameter int LAST_ADDR = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Run,
    input  logic                HandshakeIn,
    input  logic                PCHold,
    output logic [PC_WIDTH-1:0] PC,
    output logic [1:0]          Stage,
    output logic                Handshake,
    output logic                InstrDone
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } stage_t;

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(LAST_ADDR);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

    // Kept as a plain vector so the unused code 2'b11 stays representable and recoverable.
    logic [1:0]          stage_q;
    stage_t              stage_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                done_q;
    logic                done_d;
    logic                sync1;
    logic                sync2;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        stage_d = S0;
        pc_d    = pc_q;
        done_d  = 1'b0;
        case (stage_q)
            S0: stage_d = Run ? S1 : S0;
            S1: stage_d = Run ? S2 : S1;
            S2: begin
                if (Run) begin
                    stage_d = S0;
                    if (!PCHold) begin
                        pc_d   = (pc_q == LAST_PC) ? '0 : pc_q + PC_ONE;
                        done_d = 1'b1;
                    end
                end else begin
                    stage_d = S2;
                end
            end
            default: stage_d = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= S0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values; sync2 must see the old sync1.
            stage_q <= stage_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            sync1   <= HandshakeIn;
            sync2   <= sync1;
        end
    end

    assign PC        = pc_q;
    assign Stage     = stage_q;
    assign Handshake = sync2;
    assign InstrDone = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, wrap, hold, run gating, synchroniser, reset.
// A second instance with LAST_ADDR=5 covers the short wrap.
module tb_pc_sequencer;

    localparam int PW  = 5;
    localparam int PW5 = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           Run;
    logic           HandshakeIn;
    logic           PCHold;
    logic [PW-1:0]  PC;
    logic [1:0]     Stage;
    logic           Handshake;
    logic           InstrDone;
    logic [PW5-1:0] PC5;
    logic [1:0]     Stage5;
    logic           Handshake5;
    logic           InstrDone5;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(.PC_WIDTH(PW), .LAST_ADDR(31)) dut (
        .clk(clk), .reset(reset), .Run(Run), .HandshakeIn(HandshakeIn), .PCHold(PCHold),
        .PC(PC), .Stage(Stage), .Handshake(Handshake), .InstrDone(InstrDone)
    );

    pc_sequencer #(.PC_WIDTH(PW5), .LAST_ADDR(5)) dut5 (
        .clk(clk), .reset(reset), .Run(Run), .HandshakeIn(HandshakeIn), .PCHold(PCHold),
        .PC(PC5), .Stage(Stage5), .Handshake(Handshake5), .InstrDone(InstrDone5)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves reset released on a falling edge; the next rising edge is edge 1.
    task automatic do_reset();
        reset       = 1'b1;
        Run         = 1'b0;
        PCHold      = 1'b0;
        HandshakeIn = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        Run         = 1'b1;
        PCHold      = 1'b0;
        HandshakeIn = 1'b1;
        step(3);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: Stage=%b PC=%0d InstrDone=%b, want 00/0/0", Stage, PC, InstrDone);
        end
        n_checks++;
        if (Handshake !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_handshake: Handshake=%b, want 0", Handshake);
        end
        HandshakeIn = 1'b0;
    endtask

    task automatic test_sequence();
        logic [1:0]    exp_st;
        logic [PW-1:0] exp_pc;
        logic          exp_done;
        do_reset();
        Run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_st   = 2'(i % 3);
            exp_pc   = PW'(i / 3);
            exp_done = (i == 3 || i == 6);
            n_checks++;
            if ({Stage, PC, InstrDone} !== {exp_st, exp_pc, exp_done}) begin
                n_errors++;
                $display("FAIL sequence[%0d]: Stage=%b PC=%0d InstrDone=%b, want %b/%0d/%b",
                         i, Stage, PC, InstrDone, exp_st, exp_pc, exp_done);
            end
            step(1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        Run = 1'b1;
        step(15);
        n_checks++;
        if ({Stage5, PC5} !== {2'b00, 3'd5}) begin
            n_errors++;
            $display("FAIL wrap5_at_last: Stage=%b PC=%0d, want 00/5", Stage5, PC5);
        end
        step(3);
        n_checks++;
        if ({Stage5, PC5, InstrDone5} !== {2'b00, 3'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL wrap5: Stage=%b PC=%0d InstrDone=%b, want 00/0/1", Stage5, PC5, InstrDone5);
        end
        step(75);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd31, 1'b1}) begin
            n_errors++;
            $display("FAIL wrap31_at_last: Stage=%b PC=%0d InstrDone=%b, want 00/31/1", Stage, PC, InstrDone);
        end
        step(2);
        PCHold = 1'b1;
        step(1);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd31, 1'b0}) begin
            n_errors++;
            $display("FAIL hold_at_last: Stage=%b PC=%0d InstrDone=%b, want 00/31/0", Stage, PC, InstrDone);
        end
        PCHold = 1'b0;
        step(3);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL wrap31: Stage=%b PC=%0d InstrDone=%b, want 00/0/1", Stage, PC, InstrDone);
        end
    endtask

    task automatic test_hold();
        logic [1:0] exp_st;
        do_reset();
        Run = 1'b1;
        step(11);
        n_checks++;
        if ({Stage, PC} !== {2'b10, 5'd3}) begin
            n_errors++;
            $display("FAIL hold_setup: Stage=%b PC=%0d, want 10/3", Stage, PC);
        end
        PCHold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            exp_st = 2'(i % 3);
            n_checks++;
            if ({Stage, PC, InstrDone} !== {exp_st, 5'd3, 1'b0}) begin
                n_errors++;
                $display("FAIL hold_loop[%0d]: Stage=%b PC=%0d InstrDone=%b, want %b/3/0",
                         i, Stage, PC, InstrDone, exp_st);
            end
        end
        PCHold = 1'b0;
        step(1);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd4, 1'b1}) begin
            n_errors++;
            $display("FAIL hold_release: Stage=%b PC=%0d InstrDone=%b, want 00/4/1", Stage, PC, InstrDone);
        end
        PCHold = 1'b1;
        step(2);
        PCHold = 1'b0;
        step(1);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd5, 1'b1}) begin
            n_errors++;
            $display("FAIL hold_ignored_s0s1: Stage=%b PC=%0d InstrDone=%b, want 00/5/1", Stage, PC, InstrDone);
        end
    endtask

    task automatic test_handshake();
        HandshakeIn = 1'b1;
        #1;
        n_checks++;
        if (Handshake !== 1'b0) begin
            n_errors++;
            $display("FAIL hs_no_comb_path: Handshake=%b, want 0", Handshake);
        end
        step(1);
        n_checks++;
        if (Handshake !== 1'b0) begin
            n_errors++;
            $display("FAIL hs_rise_edge1: Handshake=%b, want 0", Handshake);
        end
        step(1);
        n_checks++;
        if (Handshake !== 1'b1) begin
            n_errors++;
            $display("FAIL hs_rise_edge2: Handshake=%b, want 1", Handshake);
        end
        HandshakeIn = 1'b0;
        step(2);
        n_checks++;
        if (Handshake !== 1'b0) begin
            n_errors++;
            $display("FAIL hs_fall: Handshake=%b, want 0", Handshake);
        end
        HandshakeIn = 1'b1;
        step(1);
        HandshakeIn = 1'b0;
        n_checks++;
        if (Handshake !== 1'b0) begin
            n_errors++;
            $display("FAIL hs_pulse_edge1: Handshake=%b, want 0", Handshake);
        end
        step(1);
        n_checks++;
        if (Handshake !== 1'b1) begin
            n_errors++;
            $display("FAIL hs_pulse_edge2: Handshake=%b, want 1", Handshake);
        end
        step(1);
        n_checks++;
        if (Handshake !== 1'b0) begin
            n_errors++;
            $display("FAIL hs_pulse_edge3: Handshake=%b, want 0", Handshake);
        end
    endtask

    task automatic test_run_gating();
        do_reset();
        Run = 1'b1;
        step(7);
        Run         = 1'b0;
        HandshakeIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_checks++;
            if ({Stage, PC, InstrDone} !== {2'b01, 5'd2, 1'b0}) begin
                n_errors++;
                $display("FAIL run_gate[%0d]: Stage=%b PC=%0d InstrDone=%b, want 01/2/0",
                         i, Stage, PC, InstrDone);
            end
        end
        n_checks++;
        if (Handshake !== 1'b1) begin
            n_errors++;
            $display("FAIL run_gate_sync: Handshake=%b, want 1", Handshake);
        end
        HandshakeIn = 1'b0;
        Run         = 1'b1;
        step(1);
        n_checks++;
        if ({Stage, PC} !== {2'b10, 5'd2}) begin
            n_errors++;
            $display("FAIL run_resume_s2: Stage=%b PC=%0d, want 10/2", Stage, PC);
        end
        step(1);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd3, 1'b1}) begin
            n_errors++;
            $display("FAIL run_resume_s0: Stage=%b PC=%0d InstrDone=%b, want 00/3/1", Stage, PC, InstrDone);
        end
        step(2);
        Run = 1'b0;
        step(1);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b10, 5'd3, 1'b0}) begin
            n_errors++;
            $display("FAIL run_drop_in_s2: Stage=%b PC=%0d InstrDone=%b, want 10/3/0", Stage, PC, InstrDone);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        Run = 1'b1;
        step(23);
        n_checks++;
        if ({Stage, PC} !== {2'b10, 5'd7}) begin
            n_errors++;
            $display("FAIL midreset_setup: Stage=%b PC=%0d, want 10/7", Stage, PC);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL midreset_async: Stage=%b PC=%0d InstrDone=%b, want 00/0/0", Stage, PC, InstrDone);
        end
        step(1);
        reset = 1'b0;
        step(1);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b01, 5'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL midreset_release: Stage=%b PC=%0d InstrDone=%b, want 01/0/0", Stage, PC, InstrDone);
        end
    endtask

    task automatic test_illegal_state();
        do_reset();
        Run = 1'b1;
        step(4);
        Run = 1'b0;
        force dut.stage_q = 2'b11;
        #1;
        release dut.stage_q;
        step(1);
        n_checks++;
        if ({Stage, PC, InstrDone} !== {2'b00, 5'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL illegal_recover: Stage=%b PC=%0d InstrDone=%b, want 00/1/0", Stage, PC, InstrDone);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_hold();
        test_handshake();
        test_run_gating();
        test_reset_mid_op();
        test_illegal_state();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
